// File: rtl/spike_pkg.sv
// spike_pkg: FSM encodings, channel count and default timeouts shared by the spike path
package spike_pkg;
    localparam int C_NUM_CH = 4;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP = 2'd2;
    localparam int C_GAP_CYCLES = 4;
    localparam int C_ACK_TIMEOUT = 15;
    localparam logic [7:0] C_IDLE_TIMEOUT = 8'hF4;
    function automatic logic [2:0] ch_index(input logic [C_NUM_CH:1] oh);
        return oh[1] ? 3'd1 : oh[2] ? 3'd2 : oh[3] ? 3'd3 : 3'd4;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick of the first pending channel after i_ptr
module rr_pick4 import spike_pkg::*; (
    input  logic [C_NUM_CH:1] i_pend,
    input  logic [2:0]        i_ptr,
    output logic [C_NUM_CH:1] o_gnt,
    output logic              o_valid
);
    logic [7:0] w_pend2, w_first2;
    logic [3:0] w_rot, w_first;
    // rotate so the channel after i_ptr sits at bit 0, isolate lowest set bit, rotate back
    assign w_pend2  = {i_pend, i_pend};
    assign w_rot    = w_pend2[i_ptr +: 4];
    assign w_first  = w_rot & (~w_rot + 4'd1);
    assign w_first2 = {w_first, w_first};
    assign o_gnt    = w_first2[(3'd4 - i_ptr) +: 4];
    assign o_valid  = |i_pend;
endmodule

// File: rtl/spike_arbiter.sv
// spike_arbiter: round-robin serialiser of four spike channels with ack handshake, gap, drop and idle tracking
module spike_arbiter import spike_pkg::*; #(
    parameter int          P_GAP_CYCLES   = C_GAP_CYCLES,
    parameter int          P_ACK_TIMEOUT  = C_ACK_TIMEOUT,
    parameter logic [7:0]  P_IDLE_TIMEOUT = C_IDLE_TIMEOUT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:1] i_spike_req,
    input  logic       i_enable,
    input  logic       i_ack,
    output logic [4:1] o_spike_gnt,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_idle,
    output logic [7:0] o_drop_cnt
);
    localparam logic [7:0] C_ACK_LAST = 8'(P_ACK_TIMEOUT - 1);
    localparam logic [3:0] C_GAP_LAST = P_GAP_CYCLES == 0 ? 4'd0 : 4'(P_GAP_CYCLES - 1);
    logic [4:1] r_s1, r_s2, r_pend;
    logic [1:0] r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_ack_cnt, r_idle_cnt;
    logic [3:0] r_gap_cnt;
    logic [4:1] w_edge, w_pick, w_clr, w_lost;
    logic       w_pick_vld, w_tmo, w_done;
    logic [8:0] w_drop_sum;
    rr_pick4 u_pick (.i_pend(r_pend), .i_ptr(r_ptr), .o_gnt(w_pick), .o_valid(w_pick_vld));
    assign w_edge = r_s1 & ~r_s2;
    assign w_tmo  = r_state == S_GRANT && !i_ack && r_ack_cnt == C_ACK_LAST;
    assign w_done = r_state == S_GRANT && (i_ack || w_tmo);
    // a fresh edge on the channel being retired re-arms it instead of counting as lost
    assign w_clr  = w_done ? o_spike_gnt : 4'd0;
    assign w_lost = w_edge & r_pend & ~w_clr;
    assign w_drop_sum = {1'b0, o_drop_cnt} + 9'($countones(w_lost)) + {8'd0, w_tmo};
    assign o_busy = r_state != S_IDLE;
    assign o_idle = r_idle_cnt >= P_IDLE_TIMEOUT;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_pend      <= '0;
            r_state     <= S_IDLE;
            r_ptr       <= 3'd4;
            r_ack_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_idle_cnt  <= '0;
            o_spike_gnt <= '0;
            o_valid     <= 1'b0;
            o_drop_cnt  <= '0;
        end else begin
            r_s1       <= i_spike_req;
            r_s2       <= r_s1;
            r_pend     <= (r_pend & ~w_clr) | w_edge;
            o_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            r_idle_cnt <= (|w_edge || |r_pend) ? 8'd0 : o_idle ? r_idle_cnt : r_idle_cnt + 8'd1;
            case (r_state)
                S_IDLE: if (i_enable && w_pick_vld) begin
                    o_spike_gnt <= w_pick;
                    o_valid     <= 1'b1;
                    r_ack_cnt   <= '0;
                    r_state     <= S_GRANT;
                end
                S_GRANT: if (w_done) begin
                    r_ptr       <= ch_index(o_spike_gnt);
                    o_spike_gnt <= '0;
                    o_valid     <= 1'b0;
                    r_gap_cnt   <= '0;
                    r_state     <= S_GAP;
                end else r_ack_cnt <= r_ack_cnt + 8'd1;
                S_GAP: if (r_gap_cnt == C_GAP_LAST) r_state <= S_IDLE;
                       else r_gap_cnt <= r_gap_cnt + 4'd1;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_arbiter.sv
// tb_spike_arbiter: directed literal scenarios plus randomized traffic checked against a behavioural model
module tb_spike_arbiter;
    import spike_pkg::*;
    localparam int GAP  = C_GAP_CYCLES;
    localparam int ACK  = C_ACK_TIMEOUT;
    localparam int IDLE = int'(C_IDLE_TIMEOUT);
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, ack = 1'b0;
    logic [4:1] req = '0;
    logic [4:1] gnt;
    logic valid, busy, idle;
    logic [7:0] drop;
    int checks = 0, failures = 0;
    bit cmp_on = 1'b0;
    // behavioural model: granted channel number (0 = none), its age, gap cycles left, last served channel
    bit m_pend [1:4];
    int m_gch, m_age, m_gap, m_last, m_idle, m_drop;
    logic [4:1] m_h1, m_h2;
    logic [4:1] seq [$];
    logic [4:1] exp_seq [8];

    spike_arbiter dut (.i_clk(clk), .i_rst(rst), .i_spike_req(req), .i_enable(en), .i_ack(ack),
                       .o_spike_gnt(gnt), .o_valid(valid), .o_busy(busy), .o_idle(idle), .o_drop_cnt(drop));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 1; n <= 4; n++) m_pend[n] = 1'b0;
            m_gch = 0; m_age = 0; m_gap = 0; m_last = 4; m_idle = 0; m_drop = 0;
            m_h1 = '0; m_h2 = '0;
        end else begin
            logic [4:1] e;
            bit tmo, done, anyp;
            int lost;
            e = m_h1 & ~m_h2;
            tmo = m_gch != 0 && !ack && m_age == ACK - 1;
            done = m_gch != 0 && (ack || tmo);
            lost = 0;
            anyp = 1'b0;
            for (int n = 1; n <= 4; n++) begin
                if (e[n] && m_pend[n] && !(done && n == m_gch)) lost++;
                anyp |= m_pend[n];
            end
            m_drop = m_drop + lost + int'(tmo);
            if (m_drop > 255) m_drop = 255;
            m_idle = (e != 0 || anyp) ? 0 : (m_idle < IDLE ? m_idle + 1 : m_idle);
            if (m_gch != 0) begin
                if (done) begin
                    m_pend[m_gch] = 1'b0;
                    m_last = m_gch;
                    m_gch = 0;
                    m_gap = GAP > 0 ? GAP : 1;
                end else m_age++;
            end else if (m_gap > 0) m_gap--;
            else if (en && anyp) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last + k - 1) % 4 + 1;
                    if (m_pend[c]) begin
                        m_gch = c;
                        m_age = 0;
                        break;
                    end
                end
            end
            for (int n = 1; n <= 4; n++) if (e[n]) m_pend[n] = 1'b1;
            m_h2 = m_h1;
            m_h1 = req;
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_on) begin
            chk("model_gnt", 32'(gnt), m_gch == 0 ? 32'd0 : 32'd1 << (m_gch - 1));
            chk("model_valid", 32'(valid), 32'(m_gch != 0));
            chk("model_busy", 32'(busy), 32'(m_gch != 0 || m_gap > 0));
            chk("model_idle", 32'(idle), 32'(m_idle >= IDLE));
            chk("model_drop", 32'(drop), 32'(m_drop));
        end
    end

    task automatic do_reset();
        req = '0; en = 1'b1; ack = 1'b0; rst = 1'b1;
        tick(2);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_idle", 32'(idle), 0);
        chk("rst_drop", 32'(drop), 0);
        rst = 1'b0;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid) seq.push_back(gnt);
        end
    endtask

    initial begin
        bit found;
        int nv;
        logic [3:0] flip;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        cmp_on = 1'b1;
        // single channel 3 latency and grant spacing
        ack = 1'b1;
        req = 4'b0100;
        tick(); req = 4'b0000;
        tick(); chk("lat_valid_early", 32'(valid), 0);
        req = 4'b0100;
        tick(); chk("lat_valid", 32'(valid), 1); chk("lat_gnt", 32'(gnt), 32'h4);
        nv = 0;
        for (int i = 0; i < 5; i++) begin tick(); nv += int'(valid); end
        chk("gap_no_grant", 32'(nv), 0);
        tick(); chk("gap_next_grant", 32'(valid), 1); chk("gap_next_gnt", 32'(gnt), 32'h4);
        // all four together, two rounds
        do_reset();
        seq.delete();
        ack = 1'b1; req = 4'b1111;
        collect(40);
        req = 4'b0000; tick(3); req = 4'b1111;
        collect(40);
        chk("rr_count", 32'(seq.size()), 8);
        for (int i = 0; i < 8 && i < seq.size(); i++) chk("rr_order", 32'(seq[i]), 32'(exp_seq[i]));
        chk("rr_drop", 32'(drop), 0);
        // re-edge on a pending channel plus an ack timeout
        do_reset();
        seq.delete();
        req = 4'b0010;
        collect(3); req = 4'b0000;
        collect(2); req = 4'b0010;
        collect(30);
        nv = 0;
        for (int i = 0; i < seq.size(); i++) nv += int'(seq[i] == 4'b0010);
        chk("tmo_valid_cycles", 32'(nv), 32'(ACK));
        chk("tmo_valid_after", 32'(valid), 0);
        chk("tmo_drop", 32'(drop), 2);
        // enable gating
        do_reset();
        seq.delete();
        en = 1'b0; ack = 1'b1; req = 4'b1001;
        collect(50);
        chk("en_off_grants", 32'(seq.size()), 0);
        en = 1'b1;
        collect(20);
        chk("en_on_count", 32'(seq.size()), 2);
        if (seq.size() == 2) begin
            chk("en_on_first", 32'(seq[0]), 32'h1);
            chk("en_on_second", 32'(seq[1]), 32'h8);
        end
        // inactivity timeout
        do_reset();
        tick(IDLE - 1); chk("idle_before", 32'(idle), 0);
        tick(); chk("idle_at", 32'(idle), 1);
        tick(20); chk("idle_hold", 32'(idle), 1);
        req = 4'b0001;
        tick(); chk("idle_edge_pending", 32'(idle), 1);
        tick(); chk("idle_cleared", 32'(idle), 0);
        // drop saturation, then async reset in the middle of a grant
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin req = 4'b1111; tick(); req = 4'b0000; tick(); end
        chk("drop_sat", 32'(drop), 32'hFF);
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin tick(); found = valid; end
        chk("grant_before_rst", 32'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 0);
        chk("async_valid", 32'(valid), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_drop", 32'(drop), 0);
        // randomized traffic, model-checked every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            flip = 4'($urandom) & 4'($urandom) & 4'($urandom);
            req ^= flip;
            ack = ((i / 300) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            en = $urandom_range(0, 9) != 0;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spike_arbiter.md
Name: spike_arbiter

Overview:
- Round-robin scheduler that collects spike events from four input channels and serialises them onto one downstream spike-mask/neuron input.
- Presents one granted channel at a time, with a valid/ack handshake and a programmable refractory gap between grants.
- Reports dropped events and an inactivity flag, so the system can gate clocks or reset the mask window.

Parameters:
- P_GAP_CYCLES, 4, idle cycles inserted after each completed grant (0..15).
- P_ACK_TIMEOUT, 15, cycles a grant waits for i_ack before being abandoned (1..255).
- P_IDLE_TIMEOUT, 8'hF4, cycles with no pending and no new event before o_idle asserts.

Ports:
- i_clk  in  1  single clock; all logic on posedge.
- i_rst  in  1  asynchronous, active-high reset.
- i_spike_req  in  [4:1]  per-channel spike level; an event is a 0->1 transition.
- i_enable  in  1  permits new grants; does not abort a grant in flight.
- i_ack  in  1  downstream accepts current grant.
- o_spike_gnt  out  [4:1]  one-hot granted channel, stable while o_valid is high.
- o_valid  out  1  grant presented.
- o_busy  out  1  FSM not in IDLE.
- o_idle  out  1  inactivity timeout reached.
- o_drop_cnt  out  [7:0]  saturating count of lost events.

Behaviour:
- Reset (async assert, sync-free release):
  - All outputs 0; pending[4:1]=0; all counters 0.
  - Round-robin pointer = 4, so channel 1 has first priority.
- Input stage:
  - r_s1 <= i_spike_req; r_s2 <= r_s1; edge[n] = r_s1[n] & ~r_s2[n].
- Pending capture:
  - edge[n] sets pending[n].
  - If edge[n] occurs while pending[n] is already 1, the event is lost and o_drop_cnt increments.
- Drop counting:
  - o_drop_cnt adds the number of drops in the cycle (0..4, plus 1 for an ack timeout).
  - Saturates at 8'hFF and never wraps.
- FSM states: IDLE, GRANT, GAP.
  - IDLE: if i_enable=1 and |pending, select the first pending channel searching from ptr+1 upward, wrapping 4->1. Load o_spike_gnt, set o_valid=1, clear the ack counter, go to GRANT.
  - GRANT, ack path: on i_ack=1, clear pending[gnt], set ptr=gnt, o_valid=0, o_spike_gnt=0, go to GAP.
  - GRANT, timeout path: if the ack counter reaches P_ACK_TIMEOUT first, do the same as the ack path and also add one drop.
  - GAP: count P_GAP_CYCLES cycles, then go to IDLE. If P_GAP_CYCLES=0, go to IDLE on the next cycle.
  - o_busy=1 in GRANT and GAP.
- Latency:
  - Request first sampled high at edge k gives pending at edge k+1 and o_valid=1 after edge k+2, when the FSM is IDLE and enabled.
- Throughput:
  - One grant per 2+P_GAP_CYCLES cycles minimum (ack same cycle as valid counts as 1 GRANT cycle).
- Simultaneous events:
  - If a new edge on the granted channel arrives in the same cycle as its ack or timeout, set wins: pending stays 1 and no drop is counted.
  - Multiple simultaneous edges are all captured.
- i_enable dropped mid-grant:
  - The transaction completes normally.
  - Pending events are retained and not granted until re-enabled.
- Idle counter:
  - Resets on any edge or while pending≠0; otherwise increments.
  - o_idle=1 when count ≥ P_IDLE_TIMEOUT; the counter holds there, with no wrap.
  - o_idle clears the cycle after an edge is detected.
- i_ack outside GRANT is ignored.

Decomposition:
- Shared package (spike_pkg) holds:
  - FSM state encodings: IDLE=2'd0, GRANT=2'd1, GAP=2'd2.
  - Channel count constant C_NUM_CH=4.
  - Default timeout constants, shared with spike_mask's no-spike period.
- One natural sub-module: rr_pick4, a combinational round-robin selector.
  - Inputs: pending[4:1] and ptr[2:0].
  - Outputs: one-hot gnt[4:1] and valid.
  - Instantiated once; unit-testable standalone.

Test Plan:
- Reset then pulse channel 3 high at edge 10 (ack tied high, P_GAP_CYCLES=4) -> o_valid=1 with o_spike_gnt=4'b0100 after edge 12; o_valid low after edge 13; next grant no earlier than edge 18.
- Channels 1–4 rise together, ack tied high -> grants in order 1,2,3,4; second round of all four after ptr=4 -> order 1,2,3,4 again; o_drop_cnt=0.
- Channel 2 toggles 0->1->0->1 while pending, with i_ack held low -> one grant of 4'b0010; timeout after 15 cycles clears it; o_drop_cnt=2 (one re-edge drop plus one timeout).
- i_enable=0 with channels 1 and 4 pending -> no o_valid for 50 cycles; raise i_enable -> grant 4'b0001 then 4'b1000.
- No activity for 244 cycles after reset -> o_idle=1 at count 8'hF4; pulse channel 1 -> o_idle=0 the next cycle.
- Force 300 drops via repeated edges with ack low -> o_drop_cnt saturates at 8'hFF; assert i_rst mid-GRANT -> all outputs 0 immediately, without waiting for a clock edge.
